instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer.sv | 167 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute/writeback control FSM.
// Drives the imem fetch handshake, IR latch, PC strobes and regfile write
// enable, and owns the NZP condition-code register used for branches.
// Optional build macro SEQ_STALL_EN adds a stall_in port that freezes the FSM.
module instr_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clka,
  input  logic       reset_n_in,
  input  logic       start_in,
  input  logic       imem_ack_in,
  input  logic [3:0] opcode_in,
  input  logic [2:0] nzp_dec_in,
  input  logic       n_alu_in,
  input  logic       z_alu_in,
  input  logic       p_alu_in,
  output logic       imem_req_out,
  output logic       ir_latch_out,
  output logic       pc_inc_out,
  output logic       pc_load_out,
  output logic       reg_we_out,
  output logic [2:0] cc_out,
  output logic [2:0] state_out,
  output logic       halt_out,
  output logic       err_out
`ifdef SEQ_STALL_EN
  ,
  input  logic       stall_in
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             wr_q;
  logic [2:0]       nzp_q;
  logic [2:0]       cc_q;
  logic [2:0]       alu_flags;
  logic             flags_onehot;
  logic             taken;
  logic             stall;

`ifdef SEQ_STALL_EN
  assign stall = stall_in;
`else
  assign stall = 1'b0;
`endif

  assign alu_flags    = {n_alu_in, z_alu_in, p_alu_in};
  assign flags_onehot = $onehot(alu_flags);
  assign taken        = |(cc_q & nzp_q);
  assign state_out    = state;
  assign cc_out       = cc_q;

  // State register; a stall freezes the FSM, reset still wins
  always_ff @(posedge clka) begin
    if (!reset_n_in) begin
      state <= S_IDLE;
    end else if (!stall) begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_in) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack_in) begin
          state_nxt = S_DECODE;
        end else if (to_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        if (opcode_in == 4'b0000) begin
          state_nxt = S_BRANCH;
        end else if (opcode_in == 4'b1111) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC:   if (exec_cnt == '0) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Counters, captured decode fields and condition codes
  always_ff @(posedge clka) begin
    if (!reset_n_in) begin
      exec_cnt <= '0;
      to_cnt   <= '0;
      wr_q     <= 1'b0;
      nzp_q    <= 3'b000;
      cc_q     <= 3'b010;
    end else if (!stall) begin
      // Held at zero outside FETCH so every fetch starts a fresh count
      if (state != S_FETCH) begin
        to_cnt <= '0;
      end else if (!imem_ack_in) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end

      if (state == S_DECODE) begin
        wr_q     <= ~opcode_in[3];
        nzp_q    <= nzp_dec_in;
        exec_cnt <= CNT_W'(EXEC_CYCLES - 1);
      end else if (state == S_EXEC && exec_cnt != '0) begin
        exec_cnt <= exec_cnt - CNT_W'(1);
      end

      // Ambiguous flag sets (none or several) leave the codes alone
      if (state == S_WB && wr_q && flags_onehot) begin
        cc_q <= alu_flags;
      end
    end
  end

  // Strobe decode; PC/IR/regfile strobes are masked during a stall
  always_comb begin
    imem_req_out = 1'b0;
    ir_latch_out = 1'b0;
    pc_inc_out   = 1'b0;
    pc_load_out  = 1'b0;
    reg_we_out   = 1'b0;
    halt_out     = 1'b0;
    err_out      = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req_out = 1'b1;
        ir_latch_out = imem_ack_in & ~stall;
      end
      S_WB: begin
        pc_inc_out = ~stall;
        reg_we_out = wr_q & ~stall;
      end
      S_BRANCH: begin
        pc_load_out = taken & ~stall;
        pc_inc_out  = ~taken & ~stall;
      end
      S_HALT:  halt_out = 1'b1;
      S_ERR:   err_out  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed checks of reset, fetch timeout, branch,
// write-class and halt behaviour, then a random instruction stream scored
// against a queue of expected PC/regfile strobes and condition codes.
module tb_instr_sequencer;

  localparam int unsigned E = 2;
  localparam int unsigned T = 4;

  logic       clka = 1'b0;
  logic       reset_n_in, start_in, imem_ack_in;
  logic [3:0] opcode_in;
  logic [2:0] nzp_dec_in;
  logic       n_alu_in, z_alu_in, p_alu_in;
  logic       imem_req_out, ir_latch_out, pc_inc_out, pc_load_out, reg_we_out;
  logic [2:0] cc_out, state_out;
  logic       halt_out, err_out;
`ifdef SEQ_STALL_EN
  logic       stall_in;
`endif

  always #5 clka = ~clka;

  instr_sequencer #(.EXEC_CYCLES(E), .MEM_TIMEOUT(T), .CNT_W(4)) dut (
    .clka(clka), .reset_n_in(reset_n_in), .start_in(start_in),
    .imem_ack_in(imem_ack_in), .opcode_in(opcode_in), .nzp_dec_in(nzp_dec_in),
    .n_alu_in(n_alu_in), .z_alu_in(z_alu_in), .p_alu_in(p_alu_in),
    .imem_req_out(imem_req_out), .ir_latch_out(ir_latch_out),
    .pc_inc_out(pc_inc_out), .pc_load_out(pc_load_out), .reg_we_out(reg_we_out),
    .cc_out(cc_out), .state_out(state_out), .halt_out(halt_out),
`ifdef SEQ_STALL_EN
    .stall_in(stall_in),
`endif
    .err_out(err_out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard item: one PC strobe per retired instruction
  typedef struct {
    logic       inc;
    logic       ld;
    logic       we;
    logic [2:0] cc;
    int         at;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_item;
  bit         mon_en  = 1'b0;
  bit         cc_pend = 1'b0;
  logic [2:0] cc_exp_m;
  logic [2:0] m_cc;

  // Monitor: pops an expectation whenever the DUT emits a PC strobe
  always @(negedge clka) begin
    if (cc_pend) begin
      chk("cc_after", 32'(cc_out), 32'(cc_exp_m));
      cc_pend = 1'b0;
    end
    if (mon_en && (pc_inc_out || pc_load_out)) begin
      chk("pc_exclusive", 32'(pc_inc_out & pc_load_out), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_item = sb.pop_front();
        chk("pc_inc", 32'(pc_inc_out), 32'(mon_item.inc));
        chk("pc_load", 32'(pc_load_out), 32'(mon_item.ld));
        chk("reg_we", 32'(reg_we_out), 32'(mon_item.we));
        chk("latency", 32'(cyc), 32'(mon_item.at));
        cc_exp_m = mon_item.cc;
        cc_pend  = 1'b1;
      end
    end
  end

  // Waits for a fetch, holds off the ack for dly cycles, then delivers one instruction
  task automatic issue(input logic [3:0] op, input logic [2:0] nzp,
                       input logic [2:0] fl, input int dly);
    int   g = 0;
    exp_t e;
    bit   tk;
    while (imem_req_out !== 1'b1 && g < 50) begin
      @(negedge clka);
      g++;
    end
    if (imem_req_out !== 1'b1) begin
      chk("fetch_wait", 32'd0, 32'd1);
      return;
    end
    repeat (dly) @(negedge clka);
    opcode_in  = op;
    nzp_dec_in = nzp;
    {n_alu_in, z_alu_in, p_alu_in} = fl;
    imem_ack_in = 1'b1;
    if (mon_en && op != 4'hF) begin
      if (op == 4'h0) begin
        tk   = |(m_cc & nzp);
        e.inc = !tk;
        e.ld  = tk;
        e.we  = 1'b0;
        e.at  = cyc + 2;
      end else begin
        e.inc = 1'b1;
        e.ld  = 1'b0;
        e.we  = (op < 4'h8);
        if (e.we && $countones(fl) == 1) m_cc = fl;
        e.at  = cyc + 2 + int'(E);
      end
      e.cc = m_cc;
      sb.push_back(e);
    end
    @(negedge clka);
    imem_ack_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_in = 1'b0; start_in = 1'b0; imem_ack_in = 1'b0;
    opcode_in = 4'h0; nzp_dec_in = 3'b000;
    {n_alu_in, z_alu_in, p_alu_in} = 3'b000;
`ifdef SEQ_STALL_EN
    stall_in = 1'b0;
`endif
    repeat (2) @(negedge clka);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_cc", 32'(cc_out), 32'd2);
    chk("rst_strobes", 32'({imem_req_out, ir_latch_out, pc_inc_out, pc_load_out,
                            reg_we_out, halt_out, err_out}), 32'd0);
    reset_n_in = 1'b1;
    start_in   = 1'b1;
    @(negedge clka);
    start_in = 1'b0;
    chk("start_fetch", 32'(state_out), 32'd1);

    // ALU op 0011, ack on third fetch cycle, n flag set
    @(negedge clka); chk("alu_fetch2", 32'(state_out), 32'd1);
    @(negedge clka); chk("alu_fetch3", 32'(state_out), 32'd1);
    opcode_in = 4'b0011; {n_alu_in, z_alu_in, p_alu_in} = 3'b100; imem_ack_in = 1'b1;
    #1 chk("alu_ir_latch", 32'(ir_latch_out), 32'd1);
    @(negedge clka); imem_ack_in = 1'b0; chk("alu_decode", 32'(state_out), 32'd2);
    @(negedge clka); chk("alu_exec1", 32'(state_out), 32'd3);
    @(negedge clka); chk("alu_exec2", 32'(state_out), 32'd3);
    @(negedge clka);
    chk("alu_wb", 32'(state_out), 32'd4);
    chk("alu_we", 32'(reg_we_out), 32'd1);
    chk("alu_inc", 32'(pc_inc_out), 32'd1);
    chk("alu_ld", 32'(pc_load_out), 32'd0);
    @(negedge clka);
    chk("alu_refetch", 32'(state_out), 32'd1);
    chk("alu_cc", 32'(cc_out), 32'd4);

    // Branch taken (cc=100, mask 110) then not taken (mask 011)
    opcode_in = 4'b0000; nzp_dec_in = 3'b110; imem_ack_in = 1'b1;
    @(negedge clka); imem_ack_in = 1'b0;
    @(negedge clka);
    chk("br_state", 32'(state_out), 32'd5);
    chk("br_taken_ld", 32'(pc_load_out), 32'd1);
    chk("br_taken_inc", 32'(pc_inc_out), 32'd0);
    @(negedge clka); chk("br_cc", 32'(cc_out), 32'd4);
    nzp_dec_in = 3'b011; imem_ack_in = 1'b1;
    @(negedge clka); imem_ack_in = 1'b0;
    @(negedge clka);
    chk("br_nt_ld", 32'(pc_load_out), 32'd0);
    chk("br_nt_inc", 32'(pc_inc_out), 32'd1);
    @(negedge clka);

    // Non-write class 1000 with z flag: no write, cc unchanged
    opcode_in = 4'b1000; {n_alu_in, z_alu_in, p_alu_in} = 3'b010; imem_ack_in = 1'b1;
    @(negedge clka); imem_ack_in = 1'b0;
    repeat (3) @(negedge clka);
    chk("nw_wb", 32'(state_out), 32'd4);
    chk("nw_we", 32'(reg_we_out), 32'd0);
    chk("nw_inc", 32'(pc_inc_out), 32'd1);
    @(negedge clka); chk("nw_cc", 32'(cc_out), 32'd4);

`ifdef SEQ_STALL_EN
    // Stall for three cycles in WB, then release
    opcode_in = 4'b0010; {n_alu_in, z_alu_in, p_alu_in} = 3'b001; imem_ack_in = 1'b1;
    @(negedge clka); imem_ack_in = 1'b0;
    repeat (3) @(negedge clka);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_state", 32'(state_out), 32'd4);
      chk("stall_we", 32'(reg_we_out), 32'd0);
      @(negedge clka);
    end
    stall_in = 1'b0;
    #1;
    chk("unstall_we", 32'(reg_we_out), 32'd1);
    @(negedge clka);
    chk("unstall_fetch", 32'(state_out), 32'd1);
    chk("unstall_we_off", 32'(reg_we_out), 32'd0);
    chk("unstall_cc", 32'(cc_out), 32'd1);
`endif

    // Reset in the middle of EXEC
    opcode_in = 4'b0101; imem_ack_in = 1'b1;
    @(negedge clka); imem_ack_in = 1'b0;
    @(negedge clka); chk("mid_exec", 32'(state_out), 32'd3);
    reset_n_in = 1'b0;
    repeat (2) @(negedge clka);
    chk("midrst_state", 32'(state_out), 32'd0);
    chk("midrst_cc", 32'(cc_out), 32'd2);
    chk("midrst_strobes", 32'({imem_req_out, ir_latch_out, pc_inc_out, pc_load_out,
                               reg_we_out, halt_out, err_out}), 32'd0);
    reset_n_in = 1'b1; start_in = 1'b1;
    @(negedge clka); start_in = 1'b0;
    chk("restart_fetch", 32'(state_out), 32'd1);

    // Fetch timeout with no ack
    repeat (3) @(negedge clka);
    chk("to_fetch4", 32'(state_out), 32'd1);
    @(negedge clka);
    chk("to_err_state", 32'(state_out), 32'd7);
    chk("to_err_out", 32'(err_out), 32'd1);
    chk("to_req_off", 32'(imem_req_out), 32'd0);

    // Ack on the last permitted fetch cycle wins over timeout
    reset_n_in = 1'b0;
    @(negedge clka);
    reset_n_in = 1'b1; start_in = 1'b1;
    @(negedge clka); start_in = 1'b0;
    repeat (3) @(negedge clka);
    opcode_in = 4'b0001; {n_alu_in, z_alu_in, p_alu_in} = 3'b000; imem_ack_in = 1'b1;
    #1 chk("to_ack_latch", 32'(ir_latch_out), 32'd1);
    @(negedge clka); imem_ack_in = 1'b0;
    chk("to_ack_decode", 32'(state_out), 32'd2);
    repeat (4) @(negedge clka);
    chk("noflag_cc", 32'(cc_out), 32'd2);

    // Random stream scored by the monitor
    m_cc   = 3'b010;
    mon_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 14)), 3'($urandom), 3'($urandom),
            int'($urandom_range(0, T - 1)));
    end

    // HALT holds and ignores start
    issue(4'hF, 3'b000, 3'b000, 0);
    @(negedge clka);
    chk("halt_state", 32'(state_out), 32'd6);
    chk("halt_out", 32'(halt_out), 32'd1);
    start_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clka);
      chk("halt_hold", 32'({state_out, pc_inc_out, pc_load_out, imem_req_out}),
          32'({3'd6, 3'b000}));
    end
    start_in = 1'b0;
    @(negedge clka);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
